// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
//
// Shares the single ROM controller request/busy port between the ROM stream
// loader (writes) and the CPU instruction-fetch port (reads). One transaction
// is forwarded at a time. While boot is high the CPU is held off so the loader
// owns the ROM.
//
// Handshake (requester side and ROM side share the same meaning):
//   The requester raises X_request and holds it until it sees X_busy high.
//   X_busy stays high while its transaction is in flight. Completion is marked
//   by a one-cycle done pulse (ld_done, or cpu_rdata_valid for reads). Toward
//   the ROM, rom_request stays high until rom_busy is sampled high. The
//   transaction completes on the first cycle rom_busy is sampled low after that.
//
// Optional feature macro: ROM_ARB_BOOT_LOCK_EN
//   When defined, the loader is eligible only while boot is high, which
//   write-protects the ROM once boot ends. When undefined, the loader competes
//   round-robin with the CPU at any time.
//
// The FSM state is held in state_q and the owning requester in owner_q; both
// are plain registers that checkers can bind to directly.

module rom_access_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     boot,

  input  logic                     ld_request,
  input  logic [ADDRESS_WIDTH-1:0] ld_address,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_busy,
  output logic                     ld_done,

  input  logic                     cpu_request,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  output logic                     cpu_busy,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_rdata_valid,

  output logic                     rom_request,
  output logic                     rom_write,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  output logic [DATA_WIDTH-1:0]    rom_wdata,
  input  logic [DATA_WIDTH-1:0]    rom_rdata,
  input  logic                     rom_busy,
  input  logic                     rom_initialized
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  typedef enum logic {
    OWN_LD  = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  state_t                   state_q, state_d;
  owner_t                   owner_q, owner_d;
  owner_t                   last_grant_q, last_grant_d;
  logic                     rom_request_q, rom_request_d;
  logic                     rom_write_q, rom_write_d;
  logic [ADDRESS_WIDTH-1:0] rom_address_q, rom_address_d;
  logic [DATA_WIDTH-1:0]    rom_wdata_q, rom_wdata_d;
  logic                     ld_done_q, ld_done_d;
  logic [DATA_WIDTH-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic                     cpu_rdata_valid_q, cpu_rdata_valid_d;

  logic                     ld_eligible;
  logic                     cpu_eligible;
  logic                     grant_ok;
  owner_t                   winner;

  // Eligibility of each requester in the current cycle.
  always_comb begin
    cpu_eligible = cpu_request && !boot;
`ifdef ROM_ARB_BOOT_LOCK_EN
    ld_eligible  = ld_request && boot;
`else
    ld_eligible  = ld_request;
`endif
  end

  // Winner selection: a lone eligible requester wins; a tie goes to the
  // requester that was not granted last.
  always_comb begin
    grant_ok = rom_initialized && !rom_busy && (ld_eligible || cpu_eligible);
    if (ld_eligible && cpu_eligible) begin
      winner = (last_grant_q == OWN_CPU) ? OWN_LD : OWN_CPU;
    end else if (ld_eligible) begin
      winner = OWN_LD;
    end else begin
      winner = OWN_CPU;
    end
  end

  // Next-state and registered-output logic for the IDLE/REQ/BUSY sequencer.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_grant_d      = last_grant_q;
    rom_request_d     = rom_request_q;
    rom_write_d       = rom_write_q;
    rom_address_d     = rom_address_q;
    rom_wdata_d       = rom_wdata_q;
    cpu_rdata_d       = cpu_rdata_q;
    ld_done_d         = 1'b0;
    cpu_rdata_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Requests are only sampled here; nothing is queued.
        if (grant_ok) begin
          owner_d       = winner;
          last_grant_d  = winner;
          rom_request_d = 1'b1;
          state_d       = REQ;
          if (winner == OWN_LD) begin
            rom_write_d   = 1'b1;
            rom_address_d = ld_address;
            rom_wdata_d   = ld_data;
          end else begin
            rom_write_d   = 1'b0;
            rom_address_d = cpu_address;
          end
        end
      end

      REQ: begin
        // Hold the request until the controller shows it has taken it.
        if (rom_busy) begin
          rom_request_d = 1'b0;
          state_d       = BUSY;
        end
      end

      BUSY: begin
        // First low busy after the high phase marks completion.
        if (!rom_busy) begin
          state_d = IDLE;
          if (owner_q == OWN_LD) begin
            ld_done_d = 1'b1;
          end else begin
            cpu_rdata_d       = rom_rdata;
            cpu_rdata_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d       = IDLE;
        rom_request_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset; a reset
  // mid-transaction abandons it without reporting completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      owner_q           <= OWN_LD;
      last_grant_q      <= OWN_CPU;
      rom_request_q     <= 1'b0;
      rom_write_q       <= 1'b0;
      rom_address_q     <= '0;
      rom_wdata_q       <= '0;
      ld_done_q         <= 1'b0;
      cpu_rdata_q       <= '0;
      cpu_rdata_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      last_grant_q      <= last_grant_d;
      rom_request_q     <= rom_request_d;
      rom_write_q       <= rom_write_d;
      rom_address_q     <= rom_address_d;
      rom_wdata_q       <= rom_wdata_d;
      ld_done_q         <= ld_done_d;
      cpu_rdata_q       <= cpu_rdata_d;
      cpu_rdata_valid_q <= cpu_rdata_valid_d;
    end
  end

  // Per-requester busy is derived from ownership so a loser never sees busy.
  always_comb begin
    ld_busy  = (owner_q == OWN_LD)  && (state_q != IDLE);
    cpu_busy = (owner_q == OWN_CPU) && (state_q != IDLE);
  end

  assign ld_done         = ld_done_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign cpu_rdata_valid = cpu_rdata_valid_q;
  assign rom_request     = rom_request_q;
  assign rom_write       = rom_write_q;
  assign rom_address     = rom_address_q;
  assign rom_wdata       = rom_wdata_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed testbench for rom_access_arbiter. Expectations follow the
// ROM_ARB_BOOT_LOCK_EN macro when the bench is built with it defined.

module tb_rom_access_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          boot;
  logic          ld_request;
  logic [AW-1:0] ld_address;
  logic [DW-1:0] ld_data;
  logic          ld_busy;
  logic          ld_done;
  logic          cpu_request;
  logic [AW-1:0] cpu_address;
  logic          cpu_busy;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rdata_valid;
  logic          rom_request;
  logic          rom_write;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_wdata;
  logic [DW-1:0] rom_rdata;
  logic          rom_busy;
  logic          rom_initialized;

  int tests = 0;
  int fails = 0;

  rom_access_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .boot            (boot),
    .ld_request      (ld_request),
    .ld_address      (ld_address),
    .ld_data         (ld_data),
    .ld_busy         (ld_busy),
    .ld_done         (ld_done),
    .cpu_request     (cpu_request),
    .cpu_address     (cpu_address),
    .cpu_busy        (cpu_busy),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdata_valid (cpu_rdata_valid),
    .rom_request     (rom_request),
    .rom_write       (rom_write),
    .rom_address     (rom_address),
    .rom_wdata       (rom_wdata),
    .rom_rdata       (rom_rdata),
    .rom_busy        (rom_busy),
    .rom_initialized (rom_initialized)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after a grant edge (FSM in REQ): ROM shows busy for n sampled
  // cycles, then drops it. Returns just before the completion edge.
  task automatic rom_busy_for(input int n);
    rom_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check("req_low_in_busy", {31'b0, rom_request}, 32'd0);
      check("no_done_in_busy", {30'b0, ld_done, cpu_rdata_valid}, 32'd0);
    end
    rom_busy = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_request"}, {31'b0, rom_request}, 32'd0);
    check({tag, "_rom_write"}, {31'b0, rom_write}, 32'd0);
    check({tag, "_rom_address"}, {16'b0, rom_address}, 32'd0);
    check({tag, "_rom_wdata"}, {16'b0, rom_wdata}, 32'd0);
    check({tag, "_busy"}, {30'b0, ld_busy, cpu_busy}, 32'd0);
    check({tag, "_pulses"}, {30'b0, ld_done, cpu_rdata_valid}, 32'd0);
    check({tag, "_cpu_rdata"}, {16'b0, cpu_rdata}, 32'd0);
    check({tag, "_state"}, {30'b0, dut.state_q}, 32'd0);
  endtask

  logic exp_ld_first;

  initial begin
    reset = 1'b1; boot = 1'b1;
    ld_request = 1'b0; ld_address = '0; ld_data = '0;
    cpu_request = 1'b0; cpu_address = '0;
    rom_rdata = '0; rom_busy = 1'b0; rom_initialized = 1'b1;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Loader write during boot
    ld_request = 1'b1; ld_address = 16'h0005; ld_data = 16'hBEEF;
    step();
    check("ld_grant_req", {31'b0, rom_request}, 32'd1);
    check("ld_grant_busy", {30'b0, ld_busy, cpu_busy}, 32'b10);
    check("ld_write", {31'b0, rom_write}, 32'd1);
    check("ld_addr", {16'b0, rom_address}, 32'h0005);
    check("ld_wdata", {16'b0, rom_wdata}, 32'hBEEF);
    ld_request = 1'b0;
    rom_busy_for(4);
    check("ld_still_busy", {31'b0, ld_busy}, 32'd1);
    step();
    check("ld_done_pulse", {31'b0, ld_done}, 32'd1);
    check("ld_busy_clear", {31'b0, ld_busy}, 32'd0);
    check("ld_no_rvalid", {31'b0, cpu_rdata_valid}, 32'd0);
    step();
    check("ld_done_one_cycle", {31'b0, ld_done}, 32'd0);

    // CPU read held off by boot, then issued
    cpu_request = 1'b1; cpu_address = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("cpu_boot_hold_req", {31'b0, rom_request}, 32'd0);
      check("cpu_boot_hold_busy", {31'b0, cpu_busy}, 32'd0);
    end
    boot = 1'b0;
    step();
    check("cpu_grant_req", {31'b0, rom_request}, 32'd1);
    check("cpu_grant_busy", {30'b0, ld_busy, cpu_busy}, 32'b01);
    check("cpu_read", {31'b0, rom_write}, 32'd0);
    check("cpu_addr", {16'b0, rom_address}, 32'h0010);
    cpu_request = 1'b0;
    rom_busy_for(2);
    rom_rdata = 16'h1234;
    step();
    rom_rdata = 16'h0000;
    check("cpu_rvalid", {31'b0, cpu_rdata_valid}, 32'd1);
    check("cpu_rdata", {16'b0, cpu_rdata}, 32'h1234);
    check("cpu_busy_clear", {31'b0, cpu_busy}, 32'd0);
    step();
    check("cpu_rvalid_one_cycle", {31'b0, cpu_rdata_valid}, 32'd0);
    check("cpu_rdata_held", {16'b0, cpu_rdata}, 32'h1234);

    // Both requesting with boot low: last grant was CPU, so loader then CPU.
    ld_request = 1'b1; ld_address = 16'h0100; ld_data = 16'hA5A5;
    cpu_request = 1'b1; cpu_address = 16'h0200;
    for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_BOOT_LOCK_EN
      exp_ld_first = 1'b0;
`else
      exp_ld_first = (k % 2 == 0);
`endif
      step();
      check("rr_busy", {30'b0, ld_busy, cpu_busy}, exp_ld_first ? 32'b10 : 32'b01);
      check("rr_write", {31'b0, rom_write}, {31'b0, exp_ld_first});
      check("rr_addr", {16'b0, rom_address}, exp_ld_first ? 32'h0100 : 32'h0200);
      if (exp_ld_first) ld_request = 1'b0; else cpu_request = 1'b0;
      rom_busy_for(1);
      check("rr_loser_idle", {30'b0, ld_busy, cpu_busy}, exp_ld_first ? 32'b10 : 32'b01);
      step();
      check("rr_done", {30'b0, ld_done, cpu_rdata_valid}, exp_ld_first ? 32'b10 : 32'b01);
      ld_request = 1'b1; cpu_request = 1'b1;
    end
    ld_request = 1'b0; cpu_request = 1'b0;
    step();

    // ROM not initialized: no grant; after reset, loader wins the first tie.
    reset = 1'b1;
    step();
    reset = 1'b0;
    rom_initialized = 1'b0;
    ld_request = 1'b1; cpu_request = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("uninit_no_req", {31'b0, rom_request}, 32'd0);
    end
    rom_initialized = 1'b1;
    step();
    check("init_grant_req", {31'b0, rom_request}, 32'd1);
`ifdef ROM_ARB_BOOT_LOCK_EN
    check("init_tie_winner", {30'b0, ld_busy, cpu_busy}, 32'b01);
`else
    check("init_tie_winner", {30'b0, ld_busy, cpu_busy}, 32'b10);
`endif

    // Reset in BUSY abandons the transaction silently.
    rom_busy = 1'b1;
    step();
    step();
    check("pre_reset_state_busy", {30'b0, dut.state_q}, 32'd2);
    reset = 1'b1;
    rom_busy = 1'b0;
    step();
    check_all_zero("mid_reset");
    reset = 1'b0;
    ld_request = 1'b0; cpu_request = 1'b0;
    step();
    check("post_reset_no_pulse", {30'b0, ld_done, cpu_rdata_valid}, 32'd0);
    check("post_reset_idle", {30'b0, dut.state_q}, 32'd0);

    // Loader request with boot low alongside CPU reads.
    boot = 1'b0;
    ld_request = 1'b1; ld_address = 16'h0033; ld_data = 16'h5A5A;
    cpu_request = 1'b1; cpu_address = 16'h0044;
    for (int k = 0; k < 2; k++) begin
      step();
`ifdef ROM_ARB_BOOT_LOCK_EN
      check("lock_cpu_only", {30'b0, ld_busy, cpu_busy}, 32'b01);
      cpu_request = 1'b0;
`else
      check("nolock_rr", {30'b0, ld_busy, cpu_busy}, (k == 0) ? 32'b10 : 32'b01);
      if (k == 0) ld_request = 1'b0; else cpu_request = 1'b0;
`endif
      rom_busy_for(1);
      step();
      cpu_request = 1'b1;
    end
    cpu_request = 1'b0;
    step();
`ifdef ROM_ARB_BOOT_LOCK_EN
    check("lock_ld_pending", {31'b0, ld_busy}, 32'd0);
`else
    check("nolock_idle", {31'b0, rom_request}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
